// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and transmit FSM encoding for the UART TX controller.
// Pure declarations: no logic, no latency or backpressure of its own.
package uart_pkg;

    localparam logic [1:0] ADDR_STATUS  = 2'b00;
    localparam logic [1:0] ADDR_INTMASK = 2'b01;
    localparam logic [1:0] ADDR_DATA    = 2'b10;
    localparam logic [1:0] ADDR_BAUD    = 2'b11;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: snapshots the divisor at frame start and pulses bit_tick_o on the last cycle
// of every divisor+1 cycle period while enabled; no backpressure.
module uart_baud_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    assign bit_tick_o = en_i && (cnt_q == div_q);

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (start_i) begin
            cnt_d = '0;
            div_d = div_i;
        end else if (en_i) begin
            cnt_d = bit_tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Register-mapped UART transmitter: data write launches a frame (start, 8 data LSB first, stop) of
// (divisor+1)-cycle bits; writes while busy are dropped and flagged. UART_TX_PARITY_EN adds even parity.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] in,
    output logic [7:0] rdata,
    output logic       tx,
    output logic       irq
);

`ifdef UART_TX_PARITY_EN
    localparam tx_state_e AFTER_DATA = PARITY;
`else
    localparam tx_state_e AFTER_DATA = STOP;
`endif

    tx_state_e        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, intmask_q;
    logic [DIV_W-1:0] baud_q;
    logic             done_q, ovr_q;

    logic wr, wr_status, wr_data, accept, busy, bit_tick, frame_done;

    assign wr        = CS && we;
    assign wr_status = wr && (addr == ADDR_STATUS);
    assign wr_data   = wr && (addr == ADDR_DATA);
    assign busy      = (state_q != IDLE);
    assign accept    = wr_data && !busy;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk        (clk),
        .reset      (reset),
        .start_i    (accept),
        .en_i       (busy),
        .div_i      (baud_q),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        frame_done = 1'b0;
        tx         = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = in;
                    bit_idx_d = '0;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = AFTER_DATA;
                end
            end
            PARITY: begin
                // data_q still holds the byte in flight: writes are refused while busy
                tx = ^data_q;
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                tx = 1'b1;
                if (bit_tick) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            intmask_q <= '0;
            baud_q    <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            if (accept) data_q <= in;
            if (wr && addr == ADDR_INTMASK) intmask_q <= in;
            if (wr && addr == ADDR_BAUD) baud_q <= in[DIV_W-1:0];
            // set terms OR'd last so a same-cycle set beats the write-one-to-clear
            done_q <= (done_q && !(wr_status && in[ST_DONE])) || frame_done;
            ovr_q  <= (ovr_q && !(wr_status && in[ST_OVR])) || (wr_data && busy);
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (CS && !we) begin
            case (addr)
                ADDR_STATUS:  rdata = {5'b0, ovr_q, done_q, busy};
                ADDR_INTMASK: rdata = intmask_q;
                ADDR_DATA:    rdata = data_q;
                ADDR_BAUD:    rdata = 8'(baud_q);
                default:      rdata = 8'h00;
            endcase
        end
    end

    assign irq = (done_q && intmask_q[ST_DONE]) || (ovr_q && intmask_q[ST_OVR]);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected frames queued at each data write, checked bit-by-bit on tx.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       CS, we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] rdata;
    logic       tx, irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;
    frame_t sb[$];

    uart_tx_ctrl #(.DIV_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .CS    (CS),
        .we    (we),
        .addr  (addr),
        .in    (din),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All bus tasks start and end 1ns after a rising edge; idle bus reads status.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        we = 1'b0; addr = ADDR_STATUS; din = 8'h00;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        @(negedge clk);
        chk(tag, rdata, exp);
        @(posedge clk); #1;
        addr = ADDR_STATUS;
    endtask

    task automatic send(input logic [7:0] d, input int div);
        frame_t f;
        f.data = d;
        f.div  = div;
        sb.push_back(f);
        bus_write(ADDR_DATA, d);
    endtask

    // Called right after the accepting write edge; samples every cycle of the frame.
    task automatic check_frame();
        frame_t     f;
        logic [10:0] bits;
        int         nb;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        f = sb.pop_front();
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = f.data;
`ifdef UART_TX_PARITY_EN
        bits[9] = ^f.data;
        nb = 11;
`else
        nb = 10;
`endif
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c <= f.div; c++) begin
                @(negedge clk);
                chk($sformatf("tx_bit%0d", b), tx, bits[b]);
                if (CS && !we && addr == ADDR_STATUS) chk("busy_in_frame", rdata[ST_BUSY], 1);
            end
        end
        @(negedge clk);
        if (CS && !we && addr == ADDR_STATUS) begin
            chk("busy_end", rdata[ST_BUSY], 0);
            chk("done_end", rdata[ST_DONE], 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; CS = 1'b1; we = 1'b0; addr = ADDR_STATUS; din = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_irq", irq, 0);
        @(posedge clk); #1;
        rd_chk("rst_status", ADDR_STATUS, 8'h00);
        rd_chk("rst_intmask", ADDR_INTMASK, 8'h00);
        rd_chk("rst_data", ADDR_DATA, 8'h00);
        rd_chk("rst_baud", ADDR_BAUD, 8'h00);

        // register readback, then frame A5 at divisor 3 with done IRQ enabled
        bus_write(ADDR_BAUD, 8'd3);
        rd_chk("baud_rb", ADDR_BAUD, 8'd3);
        bus_write(ADDR_INTMASK, 8'h02);
        rd_chk("intmask_rb", ADDR_INTMASK, 8'h02);
        send(8'hA5, 3);
        check_frame();
        chk("irq_done", irq, 1);
        bus_write(ADDR_STATUS, 8'h02);
        @(negedge clk);
        chk("irq_cleared", irq, 0);
        chk("done_cleared", rdata, 8'h00);
        @(posedge clk); #1;

        // overrun mid-frame: transmitted byte must be unchanged
        bus_write(ADDR_INTMASK, 8'h04);
        bus_write(ADDR_BAUD, 8'd2);
        send(8'h3C, 2);
        fork
            check_frame();
            begin
                repeat (7) @(posedge clk);
                #1 bus_write(ADDR_DATA, 8'h11);
            end
        join
        chk("irq_ovr", irq, 1);
        rd_chk("status_ovr", ADDR_STATUS, 8'h06);
        rd_chk("data_kept", ADDR_DATA, 8'h3C);
        bus_write(ADDR_STATUS, 8'h06);
        rd_chk("status_clr", ADDR_STATUS, 8'h00);

        // write in final STOP cycle is an overrun; the next cycle is accepted
        bus_write(ADDR_BAUD, 8'd0);
        send(8'h5A, 0);
        fork
            check_frame();
            begin
                repeat (9) @(posedge clk);
                #1 bus_write(ADDR_DATA, 8'h99);
                send(8'hC3, 0);
            end
        join
        check_frame();
        rd_chk("status_b2b", ADDR_STATUS, 8'h06);
        rd_chk("data_b2b", ADDR_DATA, 8'hC3);
        bus_write(ADDR_STATUS, 8'h06);

        // parity-aware frame at divisor 1
        bus_write(ADDR_BAUD, 8'd1);
        send(8'h07, 1);
        check_frame();
        bus_write(ADDR_STATUS, 8'h06);

        // reset mid-frame aborts without done
        bus_write(ADDR_BAUD, 8'd0);
        bus_write(ADDR_DATA, 8'hFF);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_status", rdata, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rd_chk("abort_no_done", ADDR_STATUS, 8'h00);
        rd_chk("abort_baud", ADDR_BAUD, 8'h00);
        chk("abort_irq", irq, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
